// File: rtl/iterative_alu.sv
// iterative_alu: execute-stage ALU with a single-entry valid/ready interface
// and a registered result. Non-shift ops (and zero-amount shifts) complete in
// one cycle. Shifts normally run in a 1-bit-per-cycle shifter, taking
// shamt+1 cycles.
//
// Build option: define BARREL_SHIFT_EN to use a combinational barrel shifter
// instead. Every op then has latency 1, and the SHIFT state and its counter
// disappear. Results are identical in both builds.
//
// Handshake: an op is accepted on a clock edge where in_valid & in_ready.
// SrcA, SrcB and ALUControl are sampled only on that edge. A result is handed
// over on an edge where out_valid & out_ready. While out_valid & !out_ready,
// ALUResult and Zero hold steady and no new op is accepted. in_ready is held
// low during rst and flush.
//
// Observability: the sequencer state (state, cnt, work, shift kind) lives in
// one packed struct, st_q, so checkers can bind to a single signal.
module iterative_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0]      shamt;
  logic [2:0]              funct3;
  logic                    is_shift;
  logic signed [WIDTH-1:0] srca_s;
  logic [WIDTH-1:0]        comb_result;
  logic                    ov_d;
  logic [WIDTH-1:0]        res_d;
  logic                    zero_d;

  assign shamt    = SrcB[SHAMT_W-1:0];
  assign funct3   = ALUControl[2:0];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign srca_s   = SrcA;

  // Single-cycle result. In the iterative build, shift slots pass SrcA
  // through; that path is only used for a zero shift amount.
  always_comb begin
    comb_result = '0;
    case (funct3)
      3'b000: comb_result = ALUControl[3] ? (SrcA - SrcB) : (SrcA + SrcB);
`ifdef BARREL_SHIFT_EN
      3'b001: comb_result = SrcA << shamt;
      3'b101: comb_result = ALUControl[3] ? (srca_s >>> shamt) : (SrcA >> shamt);
`else
      3'b001: comb_result = SrcA;
      3'b101: comb_result = SrcA;
`endif
      3'b010: comb_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      3'b011: comb_result = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      3'b100: comb_result = SrcA ^ SrcB;
      3'b110: comb_result = SrcA | SrcB;
      3'b111: comb_result = SrcA & SrcB;
      default: comb_result = '0;
    endcase
  end

`ifdef BARREL_SHIFT_EN

  // Next output state: accept when the output slot is free or being drained.
  always_comb begin
    ov_d     = out_valid;
    res_d    = ALUResult;
    zero_d   = Zero;
    in_ready = 1'b0;
    if (flush) begin
      ov_d = 1'b0;
    end else begin
      in_ready = !rst && (!out_valid || out_ready);
      if (out_valid && out_ready) ov_d = 1'b0;
      if (in_valid && in_ready) begin
        res_d  = comb_result;
        zero_d = (SrcA == SrcB);
        ov_d   = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      out_valid <= ov_d;
      ALUResult <= res_d;
      Zero      <= zero_d;
    end
  end

`else

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  typedef struct packed {
    state_t             state;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   work;
    logic               shl;    // 1: shift left, 0: shift right
    logic               arith;  // right shifts only: replicate the MSB
  } seq_t;

  seq_t             st_q, st_d;
  logic [WIDTH-1:0] shifted;

  // One-bit step of the iterative shifter.
  always_comb begin
    if (st_q.shl) shifted = {st_q.work[WIDTH-2:0], 1'b0};
    else          shifted = {st_q.arith & st_q.work[WIDTH-1], st_q.work[WIDTH-1:1]};
  end

  // Next-state and output logic for the IDLE/SHIFT sequencer.
  always_comb begin
    st_d     = st_q;
    ov_d     = out_valid;
    res_d    = ALUResult;
    zero_d   = Zero;
    in_ready = 1'b0;
    if (flush) begin
      st_d.state = IDLE;
      st_d.cnt   = '0;
      ov_d       = 1'b0;
    end else begin
      case (st_q.state)
        IDLE: begin
          in_ready = !rst && (!out_valid || out_ready);
          if (out_valid && out_ready) ov_d = 1'b0;
          if (in_valid && in_ready) begin
            zero_d = (SrcA == SrcB);
            if (is_shift && (shamt != '0)) begin
              st_d.state = SHIFT;
              st_d.cnt   = shamt;
              st_d.work  = SrcA;
              st_d.shl   = (funct3 == 3'b001);
              st_d.arith = ALUControl[3];
            end else begin
              res_d = comb_result;
              ov_d  = 1'b1;
            end
          end
        end
        SHIFT: begin
          st_d.work = shifted;
          st_d.cnt  = st_q.cnt - SHAMT_W'(1);
          if (st_q.cnt == SHAMT_W'(1)) begin
            st_d.state = IDLE;
            res_d      = shifted;
            ov_d       = 1'b1;
          end
        end
        default: st_d.state = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= '0;
      out_valid <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
    end else begin
      st_q      <= st_d;
      out_valid <= ov_d;
      ALUResult <= res_d;
      Zero      <= zero_d;
    end
  end

`endif

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed corner cases plus randomized ops checked
// against an arithmetic reference model through an expected-result queue.
module tb_iterative_alu;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];  // {Zero, ALUResult}

  iterative_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: the op rules written as plain arithmetic.
  function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] ctrl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(b % WIDTH);
    case (ctrl[2:0])
      3'd0: return ctrl[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd5: begin
        if (ctrl[3] && a[WIDTH-1]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] ctrl, input logic [WIDTH-1:0] b);
    int sh;
    sh = int'(b % WIDTH);
`ifdef BARREL_SHIFT_EN
    return 1;
`else
    if ((ctrl[2:0] == 3'd1 || ctrl[2:0] == 3'd5) && sh != 0) return sh + 1;
    return 1;
`endif
  endfunction

  // Scoreboard: every result handed over must match the head of exp_q.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected_result", 64'(exp_q.size()), 64'd1);
      else check("sb_result", 64'({Zero, ALUResult}), 64'(exp_q.pop_front()));
    end
  end

  // Present one op, wait (bounded) for acceptance, then scramble the inputs
  // to show they are only sampled on accept. Returns at posedge + 1.
  task automatic drive(input logic [3:0] ctrl, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit want_out);
    int w;
    ALUControl = ctrl; SrcA = a; SrcB = b; in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready || w >= 200) break;
      w++;
    end
    if (!in_ready) check("accept_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom_range(0, 15));
    if (want_out) exp_q.push_back({(a == b), ref_result(ctrl, a, b)});
  endtask

  // Full op with out_ready high: checks latency and that in_ready stays low while busy.
  task automatic run_op(input logic [3:0] ctrl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int lat;
    drive(ctrl, a, b, 1'b1);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid || lat >= 200) break;
      check("busy_in_ready", 64'(in_ready), 64'd0);
    end
    check("latency", 64'(lat), 64'(ref_latency(ctrl, b)));
    @(posedge clk); #1;
  endtask

  logic [WIDTH-1:0] held;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; ALUControl = '0;

    // Reset for two cycles.
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_result", 64'(ALUResult), 64'd0);
    check("post_rst_zero", 64'(Zero), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed single-cycle ops.
    run_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
    run_op(4'b1000, 32'h5, 32'h5);
    run_op(4'b0010, 32'hFFFF_FFFF, 32'h1);
    run_op(4'b0011, 32'hFFFF_FFFF, 32'h1);
    run_op(4'b1100, 32'hA5A5_0F0F, 32'h0FF0_FF00);
    run_op(4'b1110, 32'h1234_0000, 32'h0000_5678);
    run_op(4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00);

    // Directed shifts.
    run_op(4'b1101, 32'h8000_0000, 32'h4);
    run_op(4'b0101, 32'h8000_0000, 32'h4);
    run_op(4'b0001, 32'h1, 32'h0000_0120);
    run_op(4'b0001, 32'h1, 32'h1F);
    run_op(4'b1001, 32'h0000_00F3, 32'hFFFF_FFE3);

    // Backpressure: result held for three cycles while a second op waits.
    out_ready = 1'b0;
    drive(4'b0000, 32'd10, 32'd20, 1'b1);
    ALUControl = 4'b1000; SrcA = 32'd9; SrcB = 32'd9; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result_held", 64'(ALUResult), 64'(ref_result(4'b0000, 32'd10, 32'd20)));
      check("bp_zero_held", 64'(Zero), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    exp_q.push_back({1'b1, ref_result(4'b1000, 32'd9, 32'd9)});
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_no_bubble", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_valid_drops", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Flush while a result is held: dropped, ALUResult keeps its value.
    out_ready = 1'b0;
    drive(4'b0110, 32'h0F00_0000, 32'h0000_00F0, 1'b0);
    @(negedge clk);
    check("flush_hold_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_hold_drop", 64'(out_valid), 64'd0);
    check("flush_hold_result", 64'(ALUResult), 64'h0F00_00F0);
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush in cycle 2 of a shamt=10 shift.
    held = ALUResult;
    drive(4'b0001, 32'h0000_0003, 32'd10, 1'b0);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready_next", 64'(in_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      check("flush_no_output", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check("flush_result_kept", 64'(ALUResult), 64'(held));
    @(posedge clk); #1;

    // Reset in the middle of a shift (operands equal so Zero would be 1).
    drive(4'b1101, 32'h8000_0014, 32'h8000_0014, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_result", 64'(ALUResult), 64'd0);
    check("mid_rst_zero", 64'(Zero), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("mid_rst_no_output", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [3:0]       c;
      logic [WIDTH-1:0] a, b;
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) a = {1'b1, a[WIDTH-2:0]};
      run_op(c, a, b);
    end

    repeat (2) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
